// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared burst/response/state types and the per-beat address step
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Address of the beat following addr. Works at 64 bits; callers truncate to
  // their own address width, which gives the mod-2^AW wrap of INCR for free.
  function automatic logic [63:0] axi_next_addr(input logic [63:0] addr,
                                                input logic [2:0]  size,
                                                input logic [7:0]  len,
                                                input burst_e      burst);
    logic [63:0] bytes;
    logic [63:0] bound;
    logic [63:0] nxt;
    bytes = 64'd1 << size;
    bound = ({56'd0, len} + 64'd1) << size;
    case (burst)
      BURST_FIXED: nxt = addr;
      BURST_WRAP:  nxt = (addr & ~(bound - 64'd1)) | ((addr + bytes) & (bound - 64'd1));
      default:     nxt = (addr & ~(bytes - 64'd1)) + bytes;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/axi_cmd_fifo.sv
// rtl/axi_cmd_fifo.sv - outstanding address-command queue with full/empty/count
module axi_cmd_fifo #(
  parameter int W     = 49,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/axi_burst_tracker.sv
// rtl/axi_burst_tracker.sv - AXI burst sequencer: command queue, beat addressing, LAST check, B response
module axi_burst_tracker
  import axi_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 64,
  parameter int IDW   = 4,
  parameter int DEPTH = 4,
  parameter int WRITE = 1
) (
  input  logic                   axi_aclk,
  input  logic                   rst_n,
  input  logic                   ax_valid_in,
  output logic                   ax_ready,
  input  logic [AW-1:0]          ax_addr_in,
  input  logic [7:0]             ax_len_in,
  input  logic [2:0]             ax_size_in,
  input  logic [1:0]             ax_burst_in,
  input  logic [IDW-1:0]         ax_id_in,
  input  logic                   d_valid_in,
  input  logic                   d_ready_in,
  input  logic                   d_last_in,
  output logic                   d_ready,
  output logic [AW-1:0]          d_addr,
  output logic [7:0]             d_beat,
  output logic                   d_last,
  output logic [IDW-1:0]         d_id,
  output logic                   d_err,
  output logic                   b_valid,
  input  logic                   b_ready_in,
  output logic [1:0]             b_resp,
  output logic [IDW-1:0]         b_id,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int         CW       = AW + 8 + 3 + 2 + IDW;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DW/8));
  localparam bit         IS_WRITE = (WRITE != 0);

  logic           ready_en_q;
  logic           fifo_full, fifo_empty, push, pop;
  logic [CW-1:0]  fifo_wdata, fifo_rdata;

  logic [AW-1:0]  h_addr;
  logic [7:0]     h_len;
  logic [2:0]     h_size;
  logic [1:0]     h_burst;
  logic [IDW-1:0] h_id;
  logic           ld_err;
  logic [2:0]     ld_size;
  burst_e         ld_burst;

  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d, addr_nxt;
  logic [7:0]     len_q, len_d, beat_q, beat_d;
  logic [2:0]     size_q, size_d;
  burst_e         burst_q, burst_d;
  logic [IDW-1:0] id_q, id_d;
  logic           err_q, err_d;
  logic           b_valid_q, b_valid_d;
  logic [1:0]     b_resp_q, b_resp_d;
  logic [IDW-1:0] b_id_q, b_id_d;

  logic           last_w, ready_w, beat_acc, beat_err, b_free;

  assign fifo_wdata = {ax_addr_in, ax_len_in, ax_size_in, ax_burst_in, ax_id_in};
  assign h_id       = fifo_rdata[IDW-1:0];
  assign h_burst    = fifo_rdata[IDW+1:IDW];
  assign h_size     = fifo_rdata[IDW+4:IDW+2];
  assign h_len      = fifo_rdata[IDW+12:IDW+5];
  assign h_addr     = fifo_rdata[CW-1:IDW+13];

  assign ax_ready = !fifo_full && ready_en_q;
  assign push     = ax_valid_in && ax_ready;

  axi_cmd_fifo #(
    .W     (CW),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk_i   (axi_aclk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (q_count)
  );

  // Beat handshake. The last beat of a write burst is held off while the
  // previous response is still unclaimed, so a response is never overwritten.
  assign last_w   = (state_q == ST_BURST) && (beat_q == len_q);
  assign ready_w  = d_ready_in && (state_q == ST_BURST) &&
                    !(IS_WRITE && last_w && b_valid_q && !b_ready_in);
  assign beat_acc = d_valid_in && ready_w;
  assign beat_err = beat_acc && (d_last_in != last_w);
  assign b_free   = !b_valid_q || b_ready_in;
  assign addr_nxt = AW'(axi_next_addr(64'(addr_q), size_q, len_q, burst_q));

  assign d_ready = ready_w;
  assign d_addr  = addr_q;
  assign d_beat  = beat_q;
  assign d_last  = last_w;
  assign d_id    = id_q;
  assign d_err   = beat_err;
  assign b_valid = IS_WRITE && b_valid_q;
  assign b_resp  = IS_WRITE ? b_resp_q : RESP_OKAY;
  assign b_id    = IS_WRITE ? b_id_q : '0;

  // Sanitise the queue head before it becomes the active burst: illegal bursts
  // and oversize beats still run len+1 beats but are flagged for SLVERR.
  always_comb begin
    ld_err   = 1'b0;
    ld_burst = BURST_INCR;
    ld_size  = h_size;
    case (h_burst)
      2'b00: ld_burst = BURST_FIXED;
      2'b01: ld_burst = BURST_INCR;
      2'b10: begin
        if (h_len == 8'd1 || h_len == 8'd3 || h_len == 8'd7 || h_len == 8'd15) ld_burst = BURST_WRAP;
        else ld_err = 1'b1;
      end
      default: ld_err = 1'b1;
    endcase
    if (h_size > MAX_SIZE) begin
      ld_size = MAX_SIZE;
      ld_err  = 1'b1;
    end
  end

  // Burst FSM next-state: load from queue, step beats, post the write response.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    id_d      = id_q;
    beat_d    = beat_q;
    err_d     = err_q;
    b_valid_d = b_valid_q && !b_ready_in;
    b_resp_d  = b_resp_q;
    b_id_d    = b_id_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          addr_d  = h_addr;
          len_d   = h_len;
          size_d  = ld_size;
          burst_d = ld_burst;
          id_d    = h_id;
          beat_d  = 8'd0;
          err_d   = ld_err;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (beat_acc) begin
          if (beat_err) err_d = 1'b1;
          if (last_w) begin
            if (IS_WRITE) begin
              if (b_free) begin
                b_valid_d = 1'b1;
                b_resp_d  = (err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
                b_id_d    = id_q;
                state_d   = ST_IDLE;
              end else begin
                state_d = ST_RESP;
              end
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            beat_d = beat_q + 8'd1;
            addr_d = addr_nxt;
          end
        end
      end
      ST_RESP: begin
        if (b_free) begin
          b_valid_d = 1'b1;
          b_resp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
          b_id_d    = id_q;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, active-burst and response registers; reset drops everything in flight.
  always_ff @(posedge axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= BURST_FIXED;
      id_q       <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      b_id_q     <= '0;
    end else begin
      ready_en_q <= 1'b1;
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      id_q       <= id_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      b_id_q     <= b_id_d;
    end
  end

endmodule
